// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam int DMEM_ADDR_W = 10;
   localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: prio breaks ties, a lone requester always wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic       winner,
   output logic       any
);

   assign any    = |req;
   assign winner = (&req) ? prio : req[PORT_AUX];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between two masters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t             state_q, state_d;
   logic               prio_q;
   logic               sel_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               winner;
   logic               any;
   logic               grant;

   rr_pick2 u_pick (
      .req    (req),
      .prio   (prio_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               grant   = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= PORT_CPU;
         sel_q   <= PORT_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            sel_q   <= winner;
            prio_q  <= ~winner;
            we_q    <= we[winner];
            addr_q  <= winner ? addr1  : addr0;
            wdata_q <= winner ? wdata1 : wdata0;
         end
         // Async memory read follows the write, so a store echoes the new word.
         if (state_q == ACCESS)
            rdata_q <= mem_dout;
      end
   end

   // Every output comes from registers, so reset removes mem_we/ack immediately.
   assign mem_we   = (state_q == ACCESS) & we_q;
   assign mem_addr = addr_q;
   assign mem_din  = wdata_q;
   assign ack      = (state_q == RESP) ? (2'b01 << sel_q) : 2'b00;
   assign rdata    = rdata_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, scoreboard of expected acks.
module tb_dmem_arbiter;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [9:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        busy;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] mem     [1024];
   logic [31:0] ref_mem [1024];
   exp_t        sbq[$];
   int          checks;
   int          errors;
   int          we_total;
   int          cyc;

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .ack      (ack),
      .rdata    (rdata),
      .busy     (busy),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port memory with asynchronous read that follows a write in progress.
   assign mem_dout = mem_we ? mem_din : mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every ack must match the next expected port and data.
   always @(negedge clk) begin
      if (mem_we === 1'b1) we_total++;
      if (ack !== 2'b00) begin
         if (sbq.size() == 0) begin
            check("spurious_ack", {30'd0, ack}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("ack_port", {30'd0, ack}, {30'd0, (2'b01 << e.port)});
            check("rdata", rdata, e.data);
         end
      end
   end

   task automatic do_access(input logic port, input logic w, input logic [9:0] a,
                            input logic [31:0] d);
      exp_t e;
      int   we0;
      int   n;
      bit   found;
      @(posedge clk); #1;
      we0 = we_total;
      if (port) begin we[1] = w; addr1 = a; wdata1 = d; req[1] = 1'b1; end
      else      begin we[0] = w; addr0 = a; wdata0 = d; req[0] = 1'b1; end
      e.port = port;
      e.data = w ? d : ref_mem[a];
      sbq.push_back(e);
      if (w) ref_mem[a] = d;
      found = 1'b0;
      n = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack[port] === 1'b1) begin found = 1'b1; n = i; break; end
      end
      check("ack_seen", {31'd0, found}, 32'd1);
      check("latency", n, 32'd2);
      check("mem_we_cycles", we_total - we0, {31'd0, w});
      @(posedge clk); #1;
      req[port] = 1'b0;
   endtask

   initial begin
      int   last;
      bit   found;
      logic exp_port;
      checks   = 0;
      errors   = 0;
      we_total = 0;
      cyc      = 0;
      for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      mem[1] = 32'h11;   ref_mem[1] = 32'h11;
      mem[2] = 32'h22;   ref_mem[2] = 32'h22;
      mem[3] = 32'h33;   ref_mem[3] = 32'h33;
      mem[4] = 32'h44;   ref_mem[4] = 32'h44;
      mem[9] = 32'hA5A5; ref_mem[9] = 32'hA5A5;
      rst_n = 1'b0;
      req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      repeat (2) @(negedge clk);
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      rst_n = 1'b1;

      // Single write then read-back on port 0, plus top-of-memory on port 1.
      do_access(1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
      check("mem5_written", mem[5], 32'hDEADBEEF);
      do_access(1'b0, 1'b0, 10'd5, 32'h0);
      do_access(1'b1, 1'b1, 10'd1023, 32'hCAFEF00D);
      do_access(1'b1, 1'b0, 10'd1023, 32'h0);

      // Port 1 alone leaves prio at 0, so contention starts with port 0.
      do_access(1'b1, 1'b0, 10'd2, 32'h0);
      @(posedge clk); #1;
      we = 2'b00; addr0 = 10'd1; addr1 = 10'd2; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.port = k[0];
         e.data = k[0] ? ref_mem[2] : ref_mem[1];
         sbq.push_back(e);
      end
      last = 0;
      for (int k = 0; k < 4; k++) begin
         exp_port = k[0];
         found = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin found = 1'b1; break; end
         end
         check("rr_ack_seen", {31'd0, found}, 32'd1);
         check("rr_order", {30'd0, ack}, {30'd0, (2'b01 << exp_port)});
         if (k > 0) check("rr_gap", cyc - last, 32'd3);
         last = cyc;
      end
      @(posedge clk); #1;
      req = 2'b00;

      // Reads with all-ones store data must never write.
      do_access(1'b0, 1'b0, 10'd3, 32'hFFFFFFFF);
      do_access(1'b1, 1'b0, 10'd4, 32'hFFFFFFFF);
      check("mem3_kept", mem[3], 32'h33);
      check("mem4_kept", mem[4], 32'h44);

      // Reset arriving in the ACCESS cycle of a write.
      @(posedge clk); #1;
      we[0] = 1'b1; addr0 = 10'd9; wdata0 = 32'h1234; req[0] = 1'b1;
      @(posedge clk); #2;
      check("access_mem_we", {31'd0, mem_we}, 32'd1);
      check("access_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_mem_we", {31'd0, mem_we}, 32'd0);
      check("arst_ack", {30'd0, ack}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_rdata", rdata, 32'd0);
      check("arst_mem_addr", {22'd0, mem_addr}, 32'd0);
      req = 2'b00; we = 2'b00;
      @(posedge clk);
      @(negedge clk);
      check("mem9_kept", mem[9], 32'hA5A5);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_ack", {30'd0, ack}, 32'd0);
      end

      // Idle stability.
      repeat (20) begin
         @(negedge clk);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_ack", {30'd0, ack}, 32'd0);
         check("idle_mem_we", {31'd0, mem_we}, 32'd0);
      end

      check("sb_empty", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
